// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter feeding one registered output slot from N_REQ FWFT requesters; grant-to-slot latency 1 cycle.
// Slot refills on the same cycle it is popped; without pop_i the slot and grant are held and no requester is popped.
module mesh_port_arbiter #(
  parameter int pckg_sz = 40,
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en_i,
  input  logic [N_REQ-1:0]           pndng_i,
  input  logic [N_REQ*pckg_sz-1:0]   data_i,
  output logic [N_REQ-1:0]           pop_o,
  output logic                       pndng_o,
  output logic [pckg_sz-1:0]         data_out,
  input  logic                       pop_i,
  output logic [ID_W-1:0]            grant_id_o,
  output logic                       stall_o,
  output logic [15:0]                pkt_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [pckg_sz-1:0]  data_q, data_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                stall_q, stall_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                free;
  logic                found;
  logic                grant;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     idx;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    stall_d = stall_q;
    cnt_d   = cnt_q;
    win     = '0;
    idx     = '0;
    found   = 1'b0;

    free = (state_q == EMPTY) || pop_i;

    // Scan starts just after the last winner and wraps modulo N_REQ.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % N_REQ);
      if (!found && pndng_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    grant = free && en_i && found;

    if (grant) begin
      state_d = FULL;
      data_d  = data_i[int'(win)*pckg_sz +: pckg_sz];
      gid_d   = win;
      last_d  = win;
    end else if (free) begin
      state_d = EMPTY;
    end

    if ((state_q == FULL) && pop_i) begin
      cnt_d = cnt_q + 16'd1;
    end

    if ((state_q == EMPTY) || pop_i) begin
      wdog_d = '0;
    end else if (wdog_q != WD_W'(TIMEOUT)) begin
      wdog_d = wdog_q + 1'b1;
    end
    stall_d = stall_q || (wdog_d == WD_W'(TIMEOUT));
  end

  // Gated by reset_n so the requester pop drops the instant reset asserts.
  always_comb begin
    pop_o = '0;
    if (grant && reset_n) begin
      pop_o = N_REQ'(1) << win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      wdog_q  <= '0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pndng_o    = (state_q == FULL);
  assign data_out   = data_q;
  assign grant_id_o = gid_q;
  assign stall_o    = stall_q;
  assign pkt_cnt_o  = cnt_q;

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Randomized bench: requester FIFOs and a queue-based arbiter model feed a scoreboard checked by a separate monitor.
module tb_mesh_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 40;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en_i = 1'b0;
  logic             pop_i = 1'b0;
  logic [N-1:0]     pndng_i = '0;
  logic [N*W-1:0]   data_i = '0;
  logic [N-1:0]     pop_o;
  logic             pndng_o;
  logic [W-1:0]     data_out;
  logic [1:0]       grant_id_o;
  logic             stall_o;
  logic [15:0]      pkt_cnt_o;

  mesh_port_arbiter #(.pckg_sz(W), .N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .pndng_i(pndng_i), .data_i(data_i),
    .pop_o(pop_o), .pndng_o(pndng_o), .data_out(data_out), .pop_i(pop_i),
    .grant_id_o(grant_id_o), .stall_o(stall_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] dat;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        expq[$];
  logic [W-1:0] rq[N][$];
  bit          rand_push = 1'b0;
  bit          rst_active = 1'b1;

  // Reference model: slot occupancy, last winner, stall timer, delivered count.
  bit m_full;
  int m_last;
  int m_wdog;
  bit m_stall;
  int m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_last  = N - 1;
    m_wdog  = 0;
    m_stall = 1'b0;
    m_cnt   = 0;
    expq.delete();
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < N; r++) begin
      pndng_i[r] = (rq[r].size() != 0);
      data_i[r*W +: W] = (rq[r].size() != 0) ? rq[r][0] : '0;
    end
  endtask

  task automatic push_req(input int r);
    logic [W-1:0] d;
    d = {8'($urandom), 32'($urandom)};
    rq[r].push_back(d);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_push) begin
      for (int r = 0; r < N; r++) begin
        if (($urandom % 10) < 3 && rq[r].size() < 4) push_req(r);
      end
    end
    drive_inputs();
  endtask

  always @(negedge clk) begin : model
    logic [N-1:0] ep;
    bit           fr;
    int           w;
    exp_t         e;
    if (!rst_active) begin
      chk("pndng_o", 64'(pndng_o), 64'(m_full));
      chk("stall_o", 64'(stall_o), 64'(m_stall));
      chk("pkt_cnt_o", 64'(pkt_cnt_o), 64'(m_cnt));
      ep = '0;
      w  = -1;
      fr = !m_full || pop_i;
      if (fr && en_i) begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && rq[(m_last + k) % N].size() != 0) w = (m_last + k) % N;
        end
      end
      if (w >= 0) ep[w] = 1'b1;
      chk("pop_o", 64'(pop_o), 64'(ep));
      if (m_full && pop_i) m_cnt = (m_cnt + 1) % 65536;
      if (!m_full || pop_i) m_wdog = 0;
      else if (m_wdog < TO) m_wdog++;
      if (m_wdog == TO) m_stall = 1'b1;
      if (w >= 0) begin
        e.id  = 2'(w);
        e.dat = rq[w].pop_front();
        expq.push_back(e);
        m_last = w;
        m_full = 1'b1;
      end else if (fr) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_active && pndng_o && pop_i) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: packet %0h delivered with none expected at %0t", data_out, $time);
      end else begin
        e = expq.pop_front();
        chk("grant_id_o", 64'(grant_id_o), 64'(e.id));
        chk("data_out", 64'(data_out), 64'(e.dat));
      end
    end
  end

  initial begin
    model_reset();
    en_i    = 1'b1;
    pop_i   = 1'b0;
    rq[0].push_back(40'hA5);
    drive_inputs();
    #23;
    chk("rst_pndng_o", 64'(pndng_o), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_grant_id", 64'(grant_id_o), 64'd0);
    chk("rst_stall_o", 64'(stall_o), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_pop_o", 64'(pop_o), 64'd0);

    // First grant after reset goes to requester 0 in the same cycle.
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    rst_active = 1'b0;
    #1;
    chk("t1_pop_o", 64'(pop_o), 64'h1);
    cycle();
    chk("t1_pndng_o", 64'(pndng_o), 64'd1);
    chk("t1_data_out", 64'(data_out), 64'hA5);
    chk("t1_grant_id", 64'(grant_id_o), 64'd0);

    // Pointer wrap: win 1, then with 0 and 1 pending the scan wraps to 0.
    pop_i = 1'b1;
    push_req(1);
    drive_inputs();
    cycle();
    chk("t4_grant1", 64'(grant_id_o), 64'd1);
    push_req(0);
    push_req(1);
    drive_inputs();
    cycle();
    chk("t4_wrap", 64'(grant_id_o), 64'd0);
    repeat (4) cycle();

    // All requesters pending with constant pop: strict rotation, one per cycle.
    for (int r = 0; r < N; r++) begin
      push_req(r);
      push_req(r);
      push_req(r);
    end
    drive_inputs();
    repeat (14) cycle();

    rand_push = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      en_i  = (($urandom % 8) != 0);
      pop_i = (($urandom % 4) != 0);
    end

    // Arbitration disabled: slot drains, no requester is popped.
    rand_push = 1'b0;
    en_i  = 1'b0;
    pop_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      while (rq[r].size() < 2) push_req(r);
    end
    drive_inputs();
    repeat (20) cycle();
    chk("en0_drained", 64'(pndng_o), 64'd0);
    en_i = 1'b1;
    repeat (6) cycle();

    // Async reset mid-burst.
    for (int r = 0; r < N; r++) begin
      while (rq[r].size() < 4) push_req(r);
    end
    drive_inputs();
    repeat (3) cycle();
    #2;
    rst_active = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("t6_pndng_o", 64'(pndng_o), 64'd0);
    chk("t6_pop_o", 64'(pop_o), 64'd0);
    chk("t6_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    rst_active = 1'b0;
    for (int r = 0; r < N; r++) begin
      while (rq[r].size() < 2) push_req(r);
    end
    drive_inputs();
    #1;
    chk("t6_first_grant", 64'(pop_o), 64'h1);

    // Watchdog: hold the slot unpopped well past TIMEOUT, then pop.
    pop_i = 1'b0;
    repeat (TO - 2) cycle();
    chk("stall_early", 64'(stall_o), 64'd0);
    repeat (12) cycle();
    chk("stall_set", 64'(stall_o), 64'd1);
    pop_i = 1'b1;
    repeat (4) cycle();
    chk("stall_sticky", 64'(stall_o), 64'd1);

    en_i = 1'b0;
    repeat (4) cycle();
    chk("sb_drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
